// File: rtl/hex_display_ctrl.sv
// Six-digit 7-segment viewer: periodic snapshot of a 32-bit word,
// shown as two alternating pages (low 24 bits / high byte + "H").
module hex_display_ctrl #(
  parameter int TICK_DIV   = 5000000,
  parameter int PAGE_TICKS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value_in,
  input  logic        hold,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic        page,
  output logic        tick
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int PW = (PAGE_TICKS > 1) ? $clog2(PAGE_TICKS) : 1;

  localparam logic [TW-1:0] CMAX = TW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PMAX = PW'(PAGE_TICKS - 1);

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_H     = 7'b0001001;

  logic [TW-1:0] cnt;
  logic [PW-1:0] pcnt;
  logic [31:0]   snap;

  function automatic logic [6:0] seg(input logic [3:0] n);
    logic [6:0] s;
    s = SEG_0;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'ha: s = 7'b0001000;
      4'hb: s = 7'b0000011;
      4'hc: s = 7'b1000110;
      4'hd: s = 7'b0100001;
      4'he: s = 7'b0000110;
      4'hf: s = 7'b0001110;
      default: s = SEG_0;
    endcase
    return s;
  endfunction

  assign tick = ~rst & (cnt == CMAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      pcnt <= '0;
      page <= 1'b0;
      snap <= '0;
    end else begin
      cnt <= (cnt == CMAX) ? '0 : cnt + TW'(1);
      if (tick) begin
        if (!hold)
          snap <= value_in;
        if (pcnt == PMAX) begin
          pcnt <= '0;
          page <= ~page;
        end else begin
          pcnt <= pcnt + PW'(1);
        end
      end
    end
  end

  // Segments follow the registered snapshot/page one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      hex0 <= SEG_0;
      hex1 <= SEG_0;
      hex2 <= SEG_0;
      hex3 <= SEG_0;
      hex4 <= SEG_0;
      hex5 <= SEG_0;
    end else if (page) begin
      hex0 <= seg(snap[27:24]);
      hex1 <= seg(snap[31:28]);
      hex2 <= SEG_BLANK;
      hex3 <= SEG_BLANK;
      hex4 <= SEG_BLANK;
      hex5 <= SEG_H;
    end else begin
      hex0 <= seg(snap[3:0]);
      hex1 <= seg(snap[7:4]);
      hex2 <= seg(snap[11:8]);
      hex3 <= seg(snap[15:12]);
      hex4 <= seg(snap[19:16]);
      hex5 <= seg(snap[23:20]);
    end
  end

endmodule
